fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage and IF/ID pipeline register of the 5-stage core: owns the PC, drives the instruction-memory address, and captures fetched instructions into IF/ID. It consumes the hazard unit's `hazard` (load-use stall of fetch/decode) and `stall_mem` (full-pipeline stall) outputs. It also applies EX-stage redirects (taken branch, rti) and performs interrupt entry with a drain sequence that saves the resume PC in `epc`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `ISR_PC`, 32'h0000_0100, interrupt service routine entry address.
- `NOP`, 32'h0000_0013, instruction word placed in IF/ID for a bubble.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `hazard`  in  1  load-use stall: hold PC and IF/ID.
- `stall_mem`  in  1  full-pipeline stall: hold every register in this block.
- `branch_taken`  in  1  taken branch/jump resolved in EX (instruction in ID/EX).
- `branch_target`  in  32  redirect address; bits [1:0] ignored and forced to 0.
- `rti`  in  1  return-from-interrupt resolved in EX.
- `interrupt`  in  1  level-sensitive interrupt request.
- `imem_addr`  out  32  instruction-memory address, combinationally equal to `pc_f`.
- `imem_rdata`  in  32  instruction word for `imem_addr`, same cycle (combinational read).
- `inst_if_id`  out  32  IF/ID instruction.
- `pc_if_id`  out  32  IF/ID PC.
- `valid_if_id`  out  1  IF/ID holds a real instruction (0 = bubble).
- `epc`  out  32  saved resume PC.
- `int_active`  out  1  executing the ISR; further interrupts masked.

## Operation
- State: `pc_f`, IF/ID register, `epc`, `int_active`, FSM {NORMAL, DRAIN}, 2-bit drain counter.
- An advancing cycle is one with `stall_mem`=0 and `hazard`=0.
- Per-edge priority:
  1. `stall_mem`=1: all state holds; redirect and interrupt inputs are ignored. EX is frozen and re-presents them.
  2. Redirect, with `branch_taken`=1, or `rti`=1 while `int_active`=1. `rti` wins if both are asserted.
     - `pc_f` <= target (`branch_target` or `epc`).
     - IF/ID <= bubble (`NOP`, `valid`=0). Overrides `hazard`.
     - `rti` also clears `int_active`.
     - In DRAIN, a `branch_taken` instead sets `epc` <= `branch_target` and leaves `pc_f` unchanged.
  3. `hazard`=1: `pc_f` and IF/ID hold.
  4. Interrupt accept. Conditions: NORMAL, `interrupt`=1, `int_active`=0, no redirect, advancing.
     - `epc` <= `pc_f`.
     - IF/ID <= bubble; `pc_f` holds.
     - FSM -> DRAIN, counter <= 2.
  5. NORMAL advancing: IF/ID <= {`imem_rdata`, `pc_f`, 1}; `pc_f` <= `pc_f`+4.
- DRAIN:
  - Each advancing cycle: IF/ID <= bubble, counter decrements.
  - On the advancing cycle with counter=1: `pc_f` <= `ISR_PC`, `int_active` <= 1, FSM -> NORMAL.
  - `hazard` holds the counter.
- `rti` with `int_active`=0 is a no-op.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values (async, immediate):
  - `pc_f`=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `inst_if_id`=`NOP`, `pc_if_id`=0, `valid_if_id`=0.
  - `epc`=0, `int_active`=0, FSM=NORMAL, counter=0.
- Reset mid-DRAIN abandons the entry; `epc` is cleared.
- Fetch latency: the instruction at `pc_f` appears in IF/ID one edge after an advancing cycle.
- Redirect penalty: one bubble. The target reaches IF/ID on the second edge after `branch_taken`.
- Interrupt entry: accept edge, then 2 drain edges, then the `ISR_PC` fetch.
  - The first ISR instruction reaches IF/ID 4 advancing edges after the accept cycle (3 bubbles).
- `interrupt` is not latched; a request dropped before acceptance is lost.
- `imem_addr` has no register stage; it changes only on clock edges or reset.

## Test plan
- Reset release, no stalls: `imem_addr` 0, 4, 8 on successive edges; IF/ID shows `pc_if_id`=0 with `valid`=1 after the first edge.
- Load-use `hazard`=1 for 1 cycle at `pc_f`=8: `pc_f` stays 8 and IF/ID keeps pc 4 for one extra cycle, then resumes.
- `stall_mem`=1 for 3 cycles with `branch_taken`=1 and `branch_target`=0x40: no change; the redirect applies on the first unstalled edge.
  - `pc_f`=0x40, one bubble, then IF/ID pc 0x40.
- `branch_taken` and `hazard` in the same cycle: redirect wins; IF/ID is a bubble and `pc_f`=target.
- `interrupt` at `pc_f`=0x20, no branches: `epc`=0x20 and 3 bubbles follow.
  - Next, `pc_f`=0x100 and `int_active`=1.
  - `rti` then gives `pc_f`=0x20 and `int_active`=0.
- `interrupt` accepted, then `branch_taken` to 0x80 on the first DRAIN cycle: `epc`=0x80, ISR still entered.
  - A second `interrupt` while `int_active`=1 is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, applies EX redirects,
// and runs interrupt entry through a short drain before jumping to the ISR.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] ISR_PC   = 32'h0000_0100,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard,
   input  logic        stall_mem,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        rti,
   input  logic        interrupt,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_if_id,
   output logic [31:0] pc_if_id,
   output logic        valid_if_id,
   output logic [31:0] epc,
   output logic        int_active
);

   typedef enum logic {NORMAL, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        valid_q, valid_d;
   logic [31:0] epc_q, epc_d;
   logic        int_active_q, int_active_d;

   logic        take_rti;
   logic        take_br;
   logic [31:0] br_target;

   // rti only counts while in the ISR; it outranks a simultaneous branch.
   assign take_rti  = rti && int_active_q;
   assign take_br   = branch_taken && !take_rti;
   assign br_target = {branch_target[31:2], 2'b00};

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path
      // through this block leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      pc_id_d      = pc_id_q;
      valid_d      = valid_q;
      epc_d        = epc_q;
      int_active_d = int_active_q;

      if (!stall_mem) begin
         if (take_rti) begin
            pc_d         = epc_q;
            int_active_d = 1'b0;
            inst_d       = NOP;
            valid_d      = 1'b0;
         end else if (take_br) begin
            inst_d  = NOP;
            valid_d = 1'b0;
            // During drain the branch is older than the saved PC, so it
            // becomes the resume point instead of steering fetch.
            if (state_q == DRAIN) epc_d = br_target;
            else                  pc_d  = br_target;
         end else if (!hazard && state_q == NORMAL) begin
            if (interrupt && !int_active_q) begin
               epc_d   = pc_q;
               inst_d  = NOP;
               valid_d = 1'b0;
               state_d = DRAIN;
               cnt_d   = 2'd2;
            end else begin
               inst_d  = imem_rdata;
               pc_id_d = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
            end
         end

         if (state_q == DRAIN && !hazard) begin
            inst_d  = NOP;
            valid_d = 1'b0;
            cnt_d   = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
               pc_d         = ISR_PC;
               int_active_d = 1'b1;
               state_d      = NORMAL;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= NORMAL;
         cnt_q        <= 2'd0;
         pc_q         <= RESET_PC;
         inst_q       <= NOP;
         pc_id_q      <= 32'd0;
         valid_q      <= 1'b0;
         epc_q        <= 32'd0;
         int_active_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         pc_id_q      <= pc_id_d;
         valid_q      <= valid_d;
         epc_q        <= epc_d;
         int_active_q <= int_active_d;
      end
   end

   assign imem_addr   = pc_q;
   assign inst_if_id  = inst_q;
   assign pc_if_id    = pc_id_q;
   assign valid_if_id = valid_q;
   assign epc         = epc_q;
   assign int_active  = int_active_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, stalls, redirects, interrupt entry/exit.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard, stall_mem, branch_taken, rti, interrupt;
   logic [31:0] branch_target;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] inst_if_id, pc_if_id, epc;
   logic        valid_if_id, int_active;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Instruction memory: each word tags its own address.
   assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .hazard       (hazard),
      .stall_mem    (stall_mem),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .rti          (rti),
      .interrupt    (interrupt),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .inst_if_id   (inst_if_id),
      .pc_if_id     (pc_if_id),
      .valid_if_id  (valid_if_id),
      .epc          (epc),
      .int_active   (int_active)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pipe(input string tag, input logic [31:0] pc, input logic [31:0] id_pc,
                           input logic v);
      check({tag, " pc_f"}, imem_addr, pc);
      check({tag, " valid"}, {31'd0, valid_if_id}, {31'd0, v});
      if (v) begin
         check({tag, " id_pc"}, pc_if_id, id_pc);
         check({tag, " inst"}, inst_if_id, {16'hC0DE, id_pc[15:0]});
      end else begin
         check({tag, " inst"}, inst_if_id, 32'h0000_0013);
      end
   endtask

   initial begin
      rst = 1'b1; hazard = 0; stall_mem = 0; branch_taken = 0; rti = 0; interrupt = 0;
      branch_target = 32'd0;
      #2;
      check("rst addr", imem_addr, 32'h0);
      check("rst inst", inst_if_id, 32'h13);
      check("rst id_pc", pc_if_id, 32'h0);
      check("rst valid", {31'd0, valid_if_id}, 32'd0);
      check("rst epc", epc, 32'h0);
      check("rst int", {31'd0, int_active}, 32'd0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;

      // plain sequential fetch
      step(); chk_pipe("f1", 32'h4, 32'h0, 1);
      step(); chk_pipe("f2", 32'h8, 32'h4, 1);

      // one-cycle load-use hazard at pc 8
      hazard = 1;
      step(); chk_pipe("hz", 32'h8, 32'h4, 1);
      hazard = 0;
      step(); chk_pipe("hz2", 32'hC, 32'h8, 1);

      // stall_mem freezes a pending redirect; low bits of target are ignored
      stall_mem = 1; branch_taken = 1; branch_target = 32'h43;
      step(); chk_pipe("sm1", 32'hC, 32'h8, 1);
      step(); chk_pipe("sm2", 32'hC, 32'h8, 1);
      step(); chk_pipe("sm3", 32'hC, 32'h8, 1);
      stall_mem = 0;
      step(); chk_pipe("br", 32'h40, 32'h0, 0);
      branch_taken = 0;
      step(); chk_pipe("br2", 32'h44, 32'h40, 1);

      // branch and hazard together: redirect wins
      branch_taken = 1; hazard = 1; branch_target = 32'h10;
      step(); chk_pipe("brhz", 32'h10, 32'h0, 0);
      branch_taken = 0; hazard = 0;
      step(); chk_pipe("brhz2", 32'h14, 32'h10, 1);
      step(); step(); step(); chk_pipe("run", 32'h20, 32'h1C, 1);

      // interrupt at pc 0x20: accept, two drain edges, ISR fetch
      interrupt = 1;
      step(); chk_pipe("acc", 32'h20, 32'h0, 0);
      check("acc epc", epc, 32'h20);
      check("acc int", {31'd0, int_active}, 32'd0);
      interrupt = 0;
      step(); chk_pipe("dr1", 32'h20, 32'h0, 0);
      step(); chk_pipe("dr2", 32'h100, 32'h0, 0);
      check("dr2 int", {31'd0, int_active}, 32'd1);
      step(); chk_pipe("isr", 32'h104, 32'h100, 1);

      // rti back to 0x20
      rti = 1;
      step(); chk_pipe("rti", 32'h20, 32'h0, 0);
      check("rti int", {31'd0, int_active}, 32'd0);
      step(); chk_pipe("rti2", 32'h24, 32'h20, 1);
      // rti outside the ISR does nothing
      step(); chk_pipe("rtinop", 32'h28, 32'h24, 1);
      rti = 0;

      // interrupt then branch on first drain cycle
      interrupt = 1;
      step(); check("acc2 epc", epc, 32'h28);
      interrupt = 0; branch_taken = 1; branch_target = 32'h80;
      step(); chk_pipe("drbr", 32'h28, 32'h0, 0);
      check("drbr epc", epc, 32'h80);
      branch_taken = 0;
      step(); chk_pipe("drbr2", 32'h100, 32'h0, 0);
      check("drbr2 int", {31'd0, int_active}, 32'd1);
      interrupt = 1;
      step(); chk_pipe("mask1", 32'h104, 32'h100, 1);
      step(); chk_pipe("mask2", 32'h108, 32'h104, 1);
      check("mask epc", epc, 32'h80);
      interrupt = 0; rti = 1;
      step(); chk_pipe("rti3", 32'h80, 32'h0, 0);
      rti = 0;

      // PC wraps modulo 2^32
      branch_taken = 1; branch_target = 32'hFFFF_FFFC;
      step(); check("wrap pc", imem_addr, 32'hFFFF_FFFC);
      branch_taken = 0;
      step(); chk_pipe("wrap1", 32'h0, 32'hFFFF_FFFC, 1);
      step(); chk_pipe("wrap2", 32'h4, 32'h0, 1);

      // reset in the middle of a drain
      interrupt = 1;
      step(); check("acc3 epc", epc, 32'h4);
      interrupt = 0;
      #2 rst = 1;
      #1;
      check("mrst epc", epc, 32'h0);
      check("mrst pc", imem_addr, 32'h0);
      check("mrst valid", {31'd0, valid_if_id}, 32'd0);
      @(negedge clk);
      rst = 0;
      step(); chk_pipe("post", 32'h4, 32'h0, 1);
      check("post int", {31'd0, int_active}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
